// File: rtl/heai_tx_pkg.sv
// Shared definitions for the TX DAC driver: ramp FSM states and small
// constant helpers used to size the datapath.
package heai_tx_pkg;

    // Ramp controller states; IDLE holds gain 0, ACTIVE holds full gain.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    // Number of I/Q channels carried by the datapath.
    localparam int NUM_CH = 2;

    // Ceiling log2 for sizing counters from parameters.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Offset-binary code for a zero sample on a dac_w-bit converter.
    function automatic int dac_midscale(input int dac_w);
        return 1 << (dac_w - 1);
    endfunction

endpackage

// File: rtl/iq_ramp_ctrl.sv
// Burst ramp controller: walks the gain counter up while samples are valid
// and down while they are not, one step per cycle, reversing direction
// immediately so the gain never jumps.
module iq_ramp_ctrl
    import heai_tx_pkg::*;
#(
    parameter int RAMP_LEN = 8,
    localparam int G_W     = clog2(RAMP_LEN) + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           iq_valid_i,
    output logic [G_W-1:0] gain_o,
    output logic           ramping_o,
    output logic           hold_load_o
);

    localparam logic [G_W-1:0] G_MAX = G_W'(RAMP_LEN);
    localparam logic [G_W-1:0] G_ONE = G_W'(1);

    ramp_state_t    state_q, state_d;
    logic [G_W-1:0] gain_q, gain_d;

    // Next state and gain; the end points (full/zero gain) are visited
    // once inside the ramp states before settling in ACTIVE/IDLE.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            IDLE: begin
                if (iq_valid_i) begin
                    state_d = RAMP_UP;
                    gain_d  = G_ONE;
                end
            end
            RAMP_UP: begin
                if (iq_valid_i) begin
                    if (gain_q == G_MAX) begin
                        state_d = ACTIVE;
                    end else begin
                        gain_d = gain_q + G_ONE;
                    end
                end else begin
                    state_d = RAMP_DOWN;
                    gain_d  = gain_q - G_ONE;
                end
            end
            ACTIVE: begin
                if (!iq_valid_i) begin
                    state_d = RAMP_DOWN;
                    gain_d  = G_MAX - G_ONE;
                end
            end
            RAMP_DOWN: begin
                if (iq_valid_i) begin
                    state_d = RAMP_UP;
                    gain_d  = gain_q + G_ONE;
                end else if (gain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gain_d = gain_q - G_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gain_d  = '0;
            end
        endcase
    end

    // State and gain registers with synchronous reset to IDLE / zero gain.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    assign gain_o      = gain_q;
    assign ramping_o   = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    // Every valid sample is captured; invalid cycles keep the last one so
    // the ramp-down fades the final burst sample.
    assign hold_load_o = iq_valid_i;

endmodule

// File: rtl/iq_dac_driver.sv
// I/Q DAC driver: applies the burst-edge gain ramp, rounds and saturates
// each channel to the DAC width, and emits offset-binary words together
// with a TX-chain enable aligned to those words.
module iq_dac_driver
    import heai_tx_pkg::*;
#(
    parameter int IN_W     = 9,
    parameter int DAC_W    = 6,
    parameter int RAMP_LEN = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iq_valid_i,
    input  logic signed [IN_W-1:0] inphase_i,
    input  logic signed [IN_W-1:0] quadrature_i,
    output logic [DAC_W-1:0]       dac_i_o,
    output logic [DAC_W-1:0]       dac_q_o,
    output logic                   txchain_en_o,
    output logic                   ramping_o
);

    localparam int G_W    = clog2(RAMP_LEN) + 1;
    localparam int G_SH   = clog2(RAMP_LEN);
    localparam int R_SH   = IN_W - DAC_W;
    // Wide enough for the full product x*g without overflow.
    localparam int P_W    = IN_W + G_W;

    localparam logic signed [P_W-1:0] RND   = P_W'(1 << (R_SH - 1));
    localparam logic signed [P_W-1:0] R_MAX = P_W'((1 << (DAC_W - 1)) - 1);
    localparam logic signed [P_W-1:0] R_MIN = P_W'(-(1 << (DAC_W - 1)));
    localparam logic [DAC_W-1:0]      MID   = DAC_W'(dac_midscale(DAC_W));

    logic [G_W-1:0] gain;
    logic           hold_load;
    logic           txchain_en_q;

    iq_ramp_ctrl #(
        .RAMP_LEN (RAMP_LEN)
    ) u_ramp_ctrl (
        .clock       (clock),
        .reset       (reset),
        .iq_valid_i  (iq_valid_i),
        .gain_o      (gain),
        .ramping_o   (ramping_o),
        .hold_load_o (hold_load)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [IN_W-1:0] x_in;
            logic signed [IN_W-1:0] hold_q;
            logic signed [P_W-1:0]  x_ext;
            logic signed [P_W-1:0]  g_ext;
            logic signed [P_W-1:0]  prod;
            logic signed [P_W-1:0]  scaled;
            logic signed [P_W-1:0]  rounded;
            logic [DAC_W-1:0]       sat;
            logic [DAC_W-1:0]       dac_word_d;
            logic [DAC_W-1:0]       dac_word_q;

            assign x_in = (gi == 0) ? inphase_i : quadrature_i;

            // Sample hold: capture on valid, keep the last sample otherwise.
            always_ff @(posedge clock) begin
                if (reset) begin
                    hold_q <= '0;
                end else if (hold_load) begin
                    hold_q <= x_in;
                end
            end

            assign x_ext   = {{G_W{hold_q[IN_W-1]}}, hold_q};
            assign g_ext   = {{(P_W - G_W){1'b0}}, gain};
            assign prod    = x_ext * g_ext;
            // Divide by the ramp length (floor), then round half-up to DAC width.
            assign scaled  = prod >>> G_SH;
            assign rounded = (scaled + RND) >>> R_SH;

            // Clamp to the signed DAC range and flip the MSB for offset binary.
            always_comb begin
                if (rounded > R_MAX) begin
                    sat = R_MAX[DAC_W-1:0];
                end else if (rounded < R_MIN) begin
                    sat = R_MIN[DAC_W-1:0];
                end else begin
                    sat = rounded[DAC_W-1:0];
                end
                dac_word_d = {~sat[DAC_W-1], sat[DAC_W-2:0]};
            end

            // Output word register; reset parks the DAC at midscale.
            always_ff @(posedge clock) begin
                if (reset) begin
                    dac_word_q <= MID;
                end else begin
                    dac_word_q <= dac_word_d;
                end
            end
        end
    endgenerate

    // Enable follows the gain that produced the word now on the DAC pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            txchain_en_q <= 1'b0;
        end else begin
            txchain_en_q <= (gain != '0);
        end
    end

    assign dac_i_o      = g_ch[0].dac_word_q;
    assign dac_q_o      = g_ch[1].dac_word_q;
    assign txchain_en_o = txchain_en_q;

endmodule

// File: tb/tb_iq_dac_driver.sv
// Self-checking bench for iq_dac_driver: directed burst scenarios with
// hand-computed pins, then randomized bursts against a behavioural model.
module tb_iq_dac_driver;

    localparam int IN_W     = 9;
    localparam int DAC_W    = 6;
    localparam int RAMP_LEN = 8;
    localparam int MID      = 1 << (DAC_W - 1);

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   iq_valid = 1'b0;
    logic signed [IN_W-1:0] inphase = '0;
    logic signed [IN_W-1:0] quadrature = '0;
    logic [DAC_W-1:0]       dac_i;
    logic [DAC_W-1:0]       dac_q;
    logic                   txchain_en;
    logic                   ramping;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Behavioural model state
    int m_g, m_prev_g, m_hold_i, m_hold_q;
    int e_di, e_dq, e_txen, e_ramp;

    always #5 clk = ~clk;

    iq_dac_driver #(
        .IN_W     (IN_W),
        .DAC_W    (DAC_W),
        .RAMP_LEN (RAMP_LEN)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .iq_valid_i   (iq_valid),
        .inphase_i    (inphase),
        .quadrature_i (quadrature),
        .dac_i_o      (dac_i),
        .dac_q_o      (dac_q),
        .txchain_en_o (txchain_en),
        .ramping_o    (ramping)
    );

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int dac_word(input int x, input int g);
        int s, r, lim;
        s   = fdiv(x * g, RAMP_LEN);
        r   = fdiv(s + (1 << (IN_W - DAC_W - 1)), 1 << (IN_W - DAC_W));
        lim = 1 << (DAC_W - 1);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim) r = -lim;
        return r + lim;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL cyc=%0d %s: got %0d expected %0d", cyc, name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic step(input logic rst, input logic v, input int xi, input int xq);
        int xi_v, xq_v;
        xi_v = xi;
        xq_v = xq;
        reset      = rst;
        iq_valid   = v;
        inphase    = xi_v[IN_W-1:0];
        quadrature = xq_v[IN_W-1:0];
        @(posedge clk);
        cyc = cyc + 1;
        if (rst) begin
            m_g = 0; m_prev_g = 0; m_hold_i = 0; m_hold_q = 0;
            e_di = MID; e_dq = MID; e_txen = 0;
        end else begin
            e_di     = dac_word(m_hold_i, m_g);
            e_dq     = dac_word(m_hold_q, m_g);
            e_txen   = (m_g != 0) ? 1 : 0;
            m_prev_g = m_g;
            if (v) m_g = (m_g < RAMP_LEN) ? m_g + 1 : RAMP_LEN;
            else   m_g = (m_g > 0) ? m_g - 1 : 0;
            if (v) begin
                m_hold_i = xi;
                m_hold_q = xq;
            end
        end
        // Ramping while strictly between end points, or on the cycle an end point is reached.
        e_ramp = ((m_g > 0 && m_g < RAMP_LEN) ||
                  (m_g != m_prev_g && (m_g == 0 || m_g == RAMP_LEN))) ? 1 : 0;
        @(negedge clk);
        chk("dac_i", int'(dac_i), e_di);
        chk("dac_q", int'(dac_q), e_dq);
        chk("txchain_en", int'(txchain_en), e_txen);
        chk("ramping", int'(ramping), e_ramp);
        $display("cyc=%0d rst=%0d v=%0d i=%0d q=%0d -> dac_i=%0d dac_q=%0d tx=%0d ramp=%0d",
                 cyc, rst, v, xi, xq, dac_i, dac_q, txchain_en, ramping);
    endtask

    function automatic int rnd_x();
        return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    endfunction

    initial begin
        int up_i[8] = '{35, 38, 41, 45, 48, 51, 54, 57};
        int up_q[8] = '{29, 26, 23, 20, 16, 13, 10, 7};
        logic v;
        @(negedge clk);

        // 1. Reset
        step(1'b1, 1'b0, 0, 0);
        chk("reset dac_i", int'(dac_i), 32);
        chk("reset dac_q", int'(dac_q), 32);
        chk("reset txen", int'(txchain_en), 0);
        chk("reset ramping", int'(ramping), 0);

        // 2. Ramp up with I=+200, Q=-200
        step(1'b0, 1'b1, 200, -200);
        chk("latency dac_i midscale", int'(dac_i), 32);
        chk("latency txen", int'(txchain_en), 0);
        chk("ramp up ramping", int'(ramping), 1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 200, -200);
            chk("ramp up dac_i", int'(dac_i), up_i[k]);
            chk("ramp up dac_q", int'(dac_q), up_q[k]);
            chk("ramp up txen", int'(txchain_en), 1);
        end
        chk("active ramping", int'(ramping), 0);

        // 3. Saturation in ACTIVE
        step(1'b0, 1'b1, 255, 0);
        step(1'b0, 1'b1, -256, 0);
        chk("sat high", int'(dac_i), 63);
        step(1'b0, 1'b1, 0, 0);
        chk("sat low", int'(dac_i), 0);
        step(1'b0, 1'b1, 200, 200);
        chk("zero", int'(dac_i), 32);

        // 4. Ramp down with junk on the sample inputs
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, rnd_x(), rnd_x());
            if (k == 7) begin
                chk("ramp down g1 dac_i", int'(dac_i), 35);
                chk("ramp down g1 txen", int'(txchain_en), 1);
            end
        end
        chk("ramp down end dac_i", int'(dac_i), 32);
        chk("ramp down end txen", int'(txchain_en), 0);
        step(1'b0, 1'b0, 0, 0);
        chk("idle ramping", int'(ramping), 0);

        // 5. Abort mid-ramp
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 120, -77);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, rnd_x(), rnd_x());

        // 6. Re-trigger during ramp-down, then reset mid-ramp
        for (int k = 0; k < 9; k++) step(1'b0, 1'b1, -150, 180);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, -150, 180);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        chk("mid-ramp reset dac_i", int'(dac_i), 32);
        chk("mid-ramp reset ramping", int'(ramping), 0);
        step(1'b0, 1'b0, 0, 0);

        // Randomized bursts, toggling stretches and occasional resets
        v = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 < 40) v = ~v;
            else if ($urandom_range(0, 9) == 0) v = ~v;
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, v, rnd_x(), rnd_x());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
